// File: rtl/hdlc_pkg.sv
// Shared types, constants and the word-wide CRC-16/X.25 step for the HDLC
// receive frame controller.
package hdlc_pkg;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_GOOD = 16'hF0B8;
  localparam logic [15:0] CRC_POLY = 16'h8408;

  localparam logic [1:0] ERR_CRC      = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_LONG     = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_DRAIN,
    ST_SKIP
  } state_t;

  // Reflected CRC over one 16-bit word, bit 0 (first on the wire) first.
  function automatic logic [15:0] crc16_x25_word(input logic [15:0] crc,
                                                 input logic [15:0] word);
    logic [15:0] c;
    // NOTE: blocking assignments are correct here; c is a local temporary
    // rewritten 16 times within a single evaluation, not a register.
    c = crc;
    for (int i = 0; i < 16; i++) begin
      if (c[0] ^ word[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hdlc_frame_buffer.sv
// Single-frame word store: one synchronous write port, one asynchronous read
// port used to replay the frame downstream.
module hdlc_frame_buffer #(
  parameter  int MAX_WORDS = 16,
  localparam int AW        = $clog2(MAX_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [MAX_WORDS];

  // NOTE: the storage has no reset; every word is written before it is read,
  // and leaving it unreset lets it map to plain flops or RAM without a clear.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hdlc_rx_frame_controller.sv
// Drains the HDLC input register, buffers one frame, checks its FCS on
// end-of-frame and replays good frames on a valid/ready stream.
module hdlc_rx_frame_controller
  import hdlc_pkg::*;
#(
  parameter  int MAX_WORDS = 16,
  localparam int AW        = $clog2(MAX_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   rx_word,
  input  logic          rx_valid,
  input  logic          rx_eof_or_abort,
  input  logic          rx_overflow,
  output logic          rx_consumed,
  output logic          rx_reset,
  output logic [15:0]   m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic [AW:0]   frame_len,
  output logic [7:0]    dropped_frames
);

  localparam logic [AW:0] WCNT_MAX = (AW+1)'(MAX_WORDS);
  localparam logic [AW:0] WCNT_SAT = (AW+1)'(MAX_WORDS + 1);

  state_t       r_state, w_state_nxt;
  logic         r_consumed, r_eof_q, r_ovf_q;
  logic [AW:0]  r_wcnt;
  logic [AW-1:0] r_rd_ptr;
  logic [15:0]  r_crc;
  logic         r_long, r_ovf, r_busy_drop;
  logic         r_frame_ok, r_frame_err, r_rx_reset;
  logic [1:0]   r_err_code;
  logic [AW:0]  r_frame_len;
  logic [7:0]   r_dropped;

  logic         w_take, w_eof_rise, w_ovf_rise, w_room, w_busy_state;
  logic         w_drain, w_beat, w_last, w_we, w_busy_nxt, w_drop_new;
  logic         w_chk_err;
  logic [1:0]   w_chk_code;
  logic [AW-1:0] w_waddr;
  logic [15:0]  w_rdata;

  assign w_take       = rx_valid & ~r_consumed;
  assign w_eof_rise   = rx_eof_or_abort & ~r_eof_q;
  assign w_ovf_rise   = rx_overflow & ~r_ovf_q;
  assign w_room       = r_wcnt < WCNT_MAX;
  assign w_busy_state = (r_state == ST_CHECK) | (r_state == ST_DRAIN);
  assign w_drain      = (r_state == ST_DRAIN);
  assign w_beat       = w_drain & m_ready;
  assign w_last       = w_drain & ({1'b0, r_rd_ptr} == r_wcnt - (AW+1)'(2));
  assign w_drop_new   = w_take & w_busy_state & ~r_busy_drop;

  assign w_we    = w_take & ((r_state == ST_IDLE) | ((r_state == ST_COLLECT) & w_room));
  assign w_waddr = (r_state == ST_IDLE) ? '0 : r_wcnt[AW-1:0];

  hdlc_frame_buffer #(.MAX_WORDS(MAX_WORDS)) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (rx_word),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_chk_err  = 1'b1;
    w_chk_code = ERR_CRC;
    if (r_ovf)                   w_chk_code = ERR_OVERFLOW;
    else if (r_long)             w_chk_code = ERR_LONG;
    else if (r_wcnt < (AW+1)'(2)) w_chk_code = ERR_SHORT;
    else if (r_crc != CRC_GOOD)  w_chk_code = ERR_CRC;
    else                         w_chk_err  = 1'b0;
  end

  // busy_drop marks a frame arriving while we are busy; it ends at that
  // frame's own end-of-frame so the next frame is not swallowed.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy_drop;
    if (w_busy_state) begin
      if (w_take)     w_busy_nxt = 1'b1;
      if (w_eof_rise) w_busy_nxt = 1'b0;
    end else if (r_state == ST_SKIP) begin
      if (w_eof_rise) w_busy_nxt = 1'b0;
    end else begin
      w_busy_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE:    if (w_take) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (w_eof_rise) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_chk_err) w_state_nxt = w_busy_nxt ? ST_SKIP : ST_IDLE;
        else           w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:   if (w_beat & w_last) w_state_nxt = w_busy_nxt ? ST_SKIP : ST_IDLE;
      ST_SKIP:    if (w_eof_rise) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_consumed  <= 1'b0;
      r_eof_q     <= 1'b0;
      r_ovf_q     <= 1'b0;
      r_wcnt      <= '0;
      r_rd_ptr    <= '0;
      r_crc       <= CRC_INIT;
      r_long      <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy_drop <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_reset  <= 1'b1;
      r_err_code  <= '0;
      r_frame_len <= '0;
      r_dropped   <= '0;
    end else begin
      r_consumed  <= rx_valid & ~r_consumed;
      r_eof_q     <= rx_eof_or_abort;
      r_ovf_q     <= rx_overflow;
      r_busy_drop <= w_busy_nxt;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_reset  <= 1'b0;
      if (w_drop_new && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;

      case (r_state)
        ST_IDLE: begin
          r_rd_ptr <= '0;
          if (w_take) begin
            r_crc  <= crc16_x25_word(CRC_INIT, rx_word);
            r_wcnt <= (AW+1)'(1);
            r_long <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (w_take) begin
            r_crc <= crc16_x25_word(r_crc, rx_word);
            if (w_room) begin
              r_wcnt <= r_wcnt + (AW+1)'(1);
            end else begin
              r_long <= 1'b1;
              r_wcnt <= WCNT_SAT;
            end
          end
          if (w_ovf_rise) r_ovf <= 1'b1;
        end
        ST_CHECK: begin
          r_rd_ptr <= '0;
          if (w_chk_err) begin
            r_frame_err <= 1'b1;
            r_rx_reset  <= 1'b1;
            r_err_code  <= w_chk_code;
          end else begin
            r_frame_ok  <= 1'b1;
            r_frame_len <= r_wcnt - (AW+1)'(1);
          end
        end
        ST_DRAIN: if (w_beat) r_rd_ptr <= r_rd_ptr + AW'(1);
        default: ;
      endcase
    end
  end

  assign rx_consumed    = r_consumed;
  assign rx_reset       = r_rx_reset;
  assign m_valid        = w_drain;
  assign m_data         = w_drain ? w_rdata : '0;
  assign m_last         = w_last;
  assign frame_ok       = r_frame_ok;
  assign frame_err      = r_frame_err;
  assign err_code       = r_err_code;
  assign frame_len      = r_frame_len;
  assign dropped_frames = r_dropped;

endmodule
